clock_div_ctrl: RTL

CLOCK_DIV_CTRL -- requirements
Module: clock_div_ctrl

---
 rtl/clk_ctrl_pkg.sv | 13 +
 rtl/div_core.sv | 50 +++++
 rtl/clock_div_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared types and constants for the clock divider controller.
// Holds the FSM state encoding and the smallest legal divide ratio.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/div_core.sv
// Period counter plus registered clock_out/tick generation.
// en and the counter describe the next cycle; divisor is the active D.
module div_core #(
    parameter int WIDTH = 16
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] divisor,
    output logic             clock_out,
    output logic             tick,
    output logic             last
);

    logic             r_act;
    logic [WIDTH-1:0] r_cnt;
    logic             r_clk;
    logic             r_tick;
    logic [WIDTH-1:0] w_half;
    logic [WIDTH-1:0] w_top;
    logic [WIDTH-1:0] w_cnt_nxt;

    assign w_half = divisor >> 1;
    assign w_top  = divisor - WIDTH'(1);
    assign last   = r_act && (r_cnt == w_top);

    // A fresh start or a wrap restarts at 0. D only changes at count 0, where
    // clock_out is always 1 and tick always 0 for any legal D, so comparing
    // against the current D is exact.
    assign w_cnt_nxt = (!en || !r_act || last) ? '0 : r_cnt + WIDTH'(1);

    // Counter and registered outputs for the coming cycle
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_act  <= 1'b0;
            r_cnt  <= '0;
            r_clk  <= 1'b0;
            r_tick <= 1'b0;
        end else begin
            r_act  <= en;
            r_cnt  <= w_cnt_nxt;
            r_clk  <= en && (w_cnt_nxt < w_half);
            r_tick <= en && (w_cnt_nxt == w_top);
        end
    end

    assign clock_out = r_clk;
    assign tick      = r_tick;

endmodule

// File: rtl/clock_div_ctrl.sv
// Clock divider controller: start/stop FSM, single-entry divisor
// staging register with boundary-aligned apply, and period counter.
module clock_div_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clock_in,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_divisor,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clock_out,
    output logic             tick,
    output logic             busy,
    output logic [7:0]       tick_count
);

    state_t           r_state;
    logic             r_busy;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] r_pend;
    logic             r_pend_vld;
    logic             r_err;
    logic [7:0]       r_tcnt;

    logic w_last;
    logic w_en;
    logic w_xfer;
    logic w_illegal;
    logic w_apply;

    assign w_xfer    = cfg_valid && !r_pend_vld;
    assign w_illegal = cfg_divisor < WIDTH'(MIN_DIV);
    assign w_apply   = r_pend_vld && ((r_state == IDLE) || w_last);

    // Will the divider be active in the next cycle
    assign w_en = !reset && (((r_state == IDLE) && start) ||
                             (r_state == RUN) ||
                             ((r_state == STOP_PEND) && !w_last));

    // Run/stop state machine with registered busy
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= RUN;
                        r_busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (stop) begin
                        r_state <= STOP_PEND;
                    end
                end
                STOP_PEND: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Divisor staging: illegal values are dropped with an error pulse
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_div      <= WIDTH'(DEFAULT_DIV);
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_xfer && w_illegal;
            if (w_apply) begin
                r_div      <= r_pend;
                r_pend_vld <= 1'b0;
            end else if (w_xfer && !w_illegal) begin
                r_pend     <= cfg_divisor;
                r_pend_vld <= 1'b1;
            end
        end
    end

    // Completed-period counter, cleared on each start
    always_ff @(posedge clock_in) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_tcnt <= '0;
        end else if (w_last) begin
            r_tcnt <= r_tcnt + 8'd1;
        end
    end

    div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clock_in (clock_in),
        .reset    (reset),
        .en       (w_en),
        .divisor  (r_div),
        .clock_out(clock_out),
        .tick     (tick),
        .last     (w_last)
    );

    assign cfg_ready  = !r_pend_vld;
    assign cfg_err    = r_err;
    assign busy       = r_busy;
    assign tick_count = r_tcnt;

endmodule
